power_spectrum_buffer: RTL
==========================

POWER_SPECTRUM_BUFFER -- requirements
Module: power_spectrum_buffer

Interface
REQ-001 SHALL have parameter NFFT, default 512, FFT length; bin count NBINS = NFFT/2+1 (257).
REQ-002 SHALL have parameter POWER_WIDTH, default 32, power sample width.
REQ-003 SHALL have parameter PTR_WIDTH, default 9, bin index width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 power_valid_i  input  1  FFT power sample strobe.
REQ-007 power_ptr_i  input  PTR_WIDTH  bin index of power_sample_i.
REQ-008 power_sample_i  input  POWER_WIDTH  unsigned power value.
REQ-009 fft_done_i  input  1  single-cycle end-of-frame pulse from FFT.
REQ-010 out_valid_o  output  1  output sample available.
REQ-011 out_ready_i  input  1  downstream (mel filterbank) accepts sample.
REQ-012 out_ptr_o  output  PTR_WIDTH  bin index of out_sample_o.
REQ-013 out_sample_o  output  POWER_WIDTH  buffered power value.
REQ-014 busy_o  output  1  high in CAPTURE or DRAIN.
REQ-015 frame_done_o  output  1  one-cycle pulse after last bin accepted.

Function
REQ-016 SHALL implement FSM IDLE -> CAPTURE -> DRAIN -> IDLE.
REQ-017 IDLE: first power_valid_i clears the 257-bit written-mask, writes sample, enters CAPTURE.
REQ-018 IDLE/CAPTURE: power_valid_i with power_ptr_i < NBINS writes buffer[ptr] and sets mask[ptr]; ptr >= NBINS ignored, no state change.
REQ-019 Duplicate ptr within a frame: last write wins.
REQ-020 fft_done_i in CAPTURE, or in IDLE with no prior write (mask cleared): enter DRAIN next cycle.
REQ-021 power_valid_i and fft_done_i same cycle: sample written, then DRAIN.
REQ-022 DRAIN: present bins 0..NBINS-1 in ascending order; out_ptr_o = bin index.
REQ-023 out_sample_o = buffer[bin] if mask[bin] set, else 0.
REQ-024 First out_valid_o SHALL assert exactly 2 cycles after the cycle fft_done_i is sampled.
REQ-025 Valid/ready: transfer when out_valid_o && out_ready_i; while out_ready_i low, out_valid_o, out_ptr_o, out_sample_o held stable.
REQ-026 With out_ready_i held high, one bin per cycle, no bubbles (257 consecutive valid cycles).
REQ-027 power_valid_i and fft_done_i in DRAIN: dropped, no buffer/mask change.
REQ-028 After bin NBINS-1 transfer: out_valid_o low next cycle, frame_done_o pulses that same cycle, return to IDLE.
REQ-029 busy_o SHALL be combinational decode of state != IDLE.

Reset
REQ-030 rst_n low: state IDLE, out_valid_o 0, out_ptr_o 0, out_sample_o 0, busy_o 0, frame_done_o 0, mask cleared; buffer contents undefined.
REQ-031 Reset mid-CAPTURE or mid-DRAIN SHALL abort frame; no frame_done_o pulse.

Configuration
REQ-032 Macro POWER_BUF_DROP_CNT_EN defined: add output drop_count_o, 16 bits, counts power_valid_i cycles dropped in DRAIN, saturates at 0xFFFF, reset 0, never cleared otherwise.
REQ-033 Macro undefined: drop_count_o port and counter absent; function otherwise identical.

Verification
REQ-034 Write bins 0..256 with value 0x1000+ptr, pulse fft_done_i, out_ready_i=1 -> out_valid_o at +2 cycles, 257 beats ptr 0..256 value 0x1000+ptr, frame_done_o once.
REQ-035 Write only bins 0,10,256 (0xAAAA5555) -> drain emits those values, all other 254 bins 0.
REQ-036 out_ready_i toggled 1-0-1 each cycle during drain -> 257 transfers, data stable while stalled, ptr strictly ascending.
REQ-037 power_valid_i ptr=300 value 0xDEAD during CAPTURE -> ignored; power_valid_i during DRAIN (5 samples) -> dropped, drop_count_o=5 with POWER_BUF_DROP_CNT_EN.
REQ-038 Last power_valid_i (ptr 256) coincident with fft_done_i -> bin 256 drains correct value.
REQ-039 rst_n low at bin 100 of drain -> outputs 0, IDLE, no frame_done_o; next full frame drains correctly.

Source files
------------

// File: rtl/power_spectrum_buffer.sv
// Captures one frame of FFT power bins into a RAM plus written-mask, then streams bins 0..NBINS-1 over valid/ready.
// Optional POWER_BUF_DROP_CNT_EN adds drop_count_o, a saturating count of samples dropped while draining.
module power_spectrum_buffer #(
    parameter int NFFT        = 512,
    parameter int POWER_WIDTH = 32,
    parameter int PTR_WIDTH   = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   power_valid_i,
    input  logic [PTR_WIDTH-1:0]   power_ptr_i,
    input  logic [POWER_WIDTH-1:0] power_sample_i,
    input  logic                   fft_done_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [PTR_WIDTH-1:0]   out_ptr_o,
    output logic [POWER_WIDTH-1:0] out_sample_o,
    output logic                   busy_o,
    output logic                   frame_done_o
`ifdef POWER_BUF_DROP_CNT_EN
    ,
    output logic [15:0]            drop_count_o
`endif
);
    localparam int NBINS = NFFT / 2 + 1;
    localparam logic [PTR_WIDTH-1:0] LAST_BIN = PTR_WIDTH'(NBINS - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic                   start_q;
    logic                   out_valid_q;
    logic [PTR_WIDTH-1:0]   out_ptr_q;
    logic                   frame_done_q;
    logic                   mask_bit_q;
    logic [NBINS-1:0]       mask_q;
    logic [POWER_WIDTH-1:0] mem [NBINS];
    logic [POWER_WIDTH-1:0] rd_data_q;

    logic                   wr_en;
    logic                   last_xfer;
    logic                   advance;
    logic [PTR_WIDTH-1:0]   rd_addr;
    logic [NBINS-1:0]       wr_onehot;

    assign wr_en     = power_valid_i && (power_ptr_i <= LAST_BIN) && (state_q != DRAIN);
    assign last_xfer = (state_q == DRAIN) && out_valid_q && out_ready_i && (out_ptr_q == LAST_BIN);
    // start_q burns the first DRAIN cycle so the first beat lands two cycles after fft_done_i
    assign advance   = (state_q == DRAIN) && !start_q && !last_xfer && (!out_valid_q || out_ready_i);
    assign rd_addr   = out_valid_q ? out_ptr_q + PTR_WIDTH'(1) : '0;
    assign wr_onehot = {{(NBINS-1){1'b0}}, 1'b1} << power_ptr_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fft_done_i)  state_d = DRAIN;
                else if (wr_en)  state_d = CAPTURE;
            end
            CAPTURE: begin
                if (fft_done_i)  state_d = DRAIN;
            end
            DRAIN: begin
                if (last_xfer)   state_d = IDLE;
            end
            default:             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_ptr_q    <= '0;
            frame_done_q <= 1'b0;
            mask_bit_q   <= 1'b0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= (state_q != DRAIN) && (state_d == DRAIN);
            frame_done_q <= last_xfer;
            // Mask is cleared at frame end too, so a bare fft_done_i in IDLE drains zeros
            if (last_xfer)
                mask_q <= '0;
            else if (wr_en)
                mask_q <= (state_q == IDLE) ? wr_onehot : (mask_q | wr_onehot);
            if (last_xfer) begin
                out_valid_q <= 1'b0;
            end else if (advance) begin
                out_valid_q <= 1'b1;
                out_ptr_q   <= rd_addr;
                mask_bit_q  <= mask_q[rd_addr];
            end
        end
    end

    // Block-RAM style storage: no reset, registered read with enable
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[power_ptr_i] <= power_sample_i;
        if (advance)
            rd_data_q <= mem[rd_addr];
    end

    assign out_valid_o  = out_valid_q;
    assign out_ptr_o    = out_ptr_q;
    assign out_sample_o = mask_bit_q ? rd_data_q : '0;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frame_done_q;

`ifdef POWER_BUF_DROP_CNT_EN
    logic [15:0] drop_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count_q <= '0;
        else if ((state_q == DRAIN) && power_valid_i && (drop_count_q != 16'hFFFF))
            drop_count_q <= drop_count_q + 16'd1;
    end

    assign drop_count_o = drop_count_q;
`endif

endmodule
